mxu_sequencer: RTL and testbench

Phase sequencer for the SIZE×SIZE systolic multiply array. On a start request it issues an accumulator clear, then runs `num_tiles` K-tiles through the array. Each tile is a LOAD phase, then a MULT phase, then an ACC phase. At the end it signals completion. It sits between the register front end, which supplies `start`, `abort` and `num_tiles`, and the array's `load_en` / `mult_en` / `acc_en` inputs.

---
 rtl/mxu_sequencer.sv | 120 ++++++++++++
 tb/tb_mxu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_sequencer.sv
// Phase sequencer for a SIZE x SIZE systolic multiply array: CLEAR, then LOAD/MULT/ACC per K-tile, then DONE.
// Latency: first enable (acc_clr) one cycle after start is sampled; a run of N tiles ends with done in cycle 2+3*SIZE*N.
// No backpressure: start is sampled only in IDLE, abort wins over start and ends any run on the next edge.
module mxu_sequencer #(
   parameter int SIZE   = 16,
   parameter int TILE_W = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [TILE_W-1:0]       num_tiles_i,
   output logic                    load_en_o,
   output logic                    mult_en_o,
   output logic                    acc_en_o,
   output logic                    acc_clr_o,
   output logic [$clog2(SIZE)-1:0] buf_row_o,
   output logic [TILE_W-1:0]       tile_idx_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    aborted_o
);

   localparam int CW = $clog2(2*SIZE);
   localparam int RW = $clog2(SIZE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      MULT  = 3'd3,
      ACC   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TILE_W-1:0] tile_q, tile_d;
   logic [TILE_W-1:0] ntiles_q, ntiles_d;
   logic              aborted_q, aborted_d;

   // Next-state, counter and tile bookkeeping; abort overrides every busy transition.
   always_comb begin
      state_d   = state_q;
      tile_d    = tile_q;
      ntiles_d  = ntiles_q;
      aborted_d = 1'b0;
      cnt_d     = '0;
      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               ntiles_d = num_tiles_i;
               if (num_tiles_i != '0) begin
                  state_d = CLEAR;
                  tile_d  = '0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CLEAR: state_d = LOAD;
         LOAD: begin
            if (cnt_q == CW'(SIZE-1)) state_d = MULT;
         end
         MULT: begin
            if (cnt_q == CW'(2*SIZE-2)) state_d = ACC;
         end
         ACC: begin
            if (tile_q == ntiles_q - TILE_W'(1)) begin
               state_d = DONE;
            end else begin
               tile_d  = tile_q + TILE_W'(1);
               state_d = LOAD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && abort_i) begin
         state_d   = IDLE;
         tile_d    = tile_q;
         aborted_d = 1'b1;
      end

      // Counter restarts from zero whenever a state is entered.
      if (state_d == state_q && state_q != IDLE) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State, counter, tile and latched-count registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tile_q    <= '0;
         ntiles_q  <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tile_q    <= tile_d;
         ntiles_q  <= ntiles_d;
         aborted_q <= aborted_d;
      end
   end

   // Outputs depend only on registered state, so there is no input-to-output path.
   assign acc_clr_o  = (state_q == CLEAR);
   assign load_en_o  = (state_q == LOAD);
   assign mult_en_o  = (state_q == MULT);
   assign acc_en_o   = (state_q == ACC);
   assign done_o     = (state_q == DONE);
   assign busy_o     = (state_q != IDLE);
   assign aborted_o  = aborted_q;
   assign tile_idx_o = tile_q;
   assign buf_row_o  = (state_q == LOAD) ? cnt_q[RW-1:0] : '0;

endmodule

// File: tb/tb_mxu_sequencer.sv
// Bench for mxu_sequencer with SIZE=4: directed test-plan steps followed by random start/abort traffic.
// Expected outputs come from a cycle-position model built on the run timeline arithmetic.
// Every cycle all outputs are compared; per-run pulse totals are also checked against fixed numbers.
module tb_mxu_sequencer;

   localparam int S  = 4;
   localparam int TW = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [TW-1:0] num_tiles;
   logic          load_en, mult_en, acc_en, acc_clr;
   logic [1:0]    buf_row;
   logic [TW-1:0] tile_idx;
   logic          busy, done, aborted;

   mxu_sequencer #(.SIZE(S), .TILE_W(TW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .num_tiles_i (num_tiles),
      .load_en_o   (load_en),
      .mult_en_o   (mult_en),
      .acc_en_o    (acc_en),
      .acc_clr_o   (acc_clr),
      .buf_row_o   (buf_row),
      .tile_idx_o  (tile_idx),
      .busy_o      (busy),
      .done_o      (done),
      .aborted_o   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Model: m_k is the cycle number within the current run (0 = idle).
   int m_k   = 0;
   int m_n   = 0;
   int m_tile = 0;
   bit m_ab  = 0;

   int c_load, c_mult, c_acc, c_clr, c_done, c_busy, c_ab;

   function automatic int last_cycle(input int n);
      return (n == 0) ? 1 : 2 + 3*S*n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int e_load, e_mult, e_acc, e_clr, e_row, e_busy, e_done, p;
      e_load = 0; e_mult = 0; e_acc = 0; e_clr = 0; e_row = 0; e_done = 0;
      e_busy = (m_k != 0) ? 1 : 0;
      if (m_k != 0) begin
         if (m_k == last_cycle(m_n)) begin
            e_done = 1;
         end else if (m_k == 1) begin
            e_clr = 1;
         end else begin
            p = (m_k - 2) % (3*S);
            if (p < S) begin
               e_load = 1;
               e_row  = p;
            end else if (p < 3*S - 1) begin
               e_mult = 1;
            end else begin
               e_acc = 1;
            end
         end
      end
      chk("load_en",  32'(load_en),  32'(e_load));
      chk("mult_en",  32'(mult_en),  32'(e_mult));
      chk("acc_en",   32'(acc_en),   32'(e_acc));
      chk("acc_clr",  32'(acc_clr),  32'(e_clr));
      chk("buf_row",  32'(buf_row),  32'(e_row));
      chk("tile_idx", 32'(tile_idx), 32'(m_tile));
      chk("busy",     32'(busy),     32'(e_busy));
      chk("done",     32'(done),     32'(e_done));
      chk("aborted",  32'(aborted),  32'(m_ab));
   endtask

   task automatic clr_counts();
      c_load = 0; c_mult = 0; c_acc = 0; c_clr = 0; c_done = 0; c_busy = 0; c_ab = 0;
   endtask

   task automatic model_reset();
      m_k = 0; m_n = 0; m_tile = 0; m_ab = 0;
   endtask

   // One clock: predict from inputs applied before the edge, then compare just after it.
   task automatic tick();
      int nk, nn;
      bit nab;
      nk = m_k; nn = m_n; nab = 0;
      if (m_k == 0) begin
         if (start && !abort) begin
            nn = int'(num_tiles);
            nk = 1;
         end
      end else if (abort) begin
         nk  = 0;
         nab = 1;
      end else if (m_k == last_cycle(m_n)) begin
         nk = 0;
      end else begin
         nk = m_k + 1;
      end
      @(posedge clk);
      #1;
      m_k = nk; m_n = nn; m_ab = nab;
      if (m_k == 1 && m_n != 0) m_tile = 0;
      if (m_n != 0 && m_k >= 2 && m_k <= 1 + 3*S*m_n) m_tile = (m_k - 2) / (3*S);
      check_all();
      c_load += int'(load_en); c_mult += int'(mult_en); c_acc += int'(acc_en);
      c_clr  += int'(acc_clr); c_done += int'(done);    c_busy += int'(busy);
      c_ab   += int'(aborted);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tiles = '0;
      clr_counts();
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;
      tick(); tick();

      // Single tile: clear, 4 loads, 7 mults, 1 acc, done in cycle 14.
      clr_counts();
      num_tiles = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 2; i <= 15; i++) tick();
      chk("t1_load_cnt", 32'(c_load), 32'd4);
      chk("t1_mult_cnt", 32'(c_mult), 32'd7);
      chk("t1_acc_cnt",  32'(c_acc),  32'd1);
      chk("t1_done_cnt", 32'(c_done), 32'd1);
      chk("t1_busy_cnt", 32'(c_busy), 32'd14);

      // Three tiles; num_tiles changed and start pulsed mid-run.
      clr_counts();
      num_tiles = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 2; i <= 40; i++) begin
         if (i == 5) num_tiles = 8'd7;
         start = (i == 10);
         tick();
      end
      start = 1'b0;
      chk("t3_clr_cnt",  32'(c_clr),  32'd1);
      chk("t3_acc_cnt",  32'(c_acc),  32'd3);
      chk("t3_load_cnt", 32'(c_load), 32'd12);
      chk("t3_done_cnt", 32'(c_done), 32'd1);
      chk("t3_busy_cnt", 32'(c_busy), 32'd38);

      // Zero tiles: done and busy for one cycle, no enables.
      clr_counts();
      num_tiles = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("t0_done_cnt", 32'(c_done), 32'd1);
      chk("t0_busy_cnt", 32'(c_busy), 32'd1);
      chk("t0_en_cnt",   32'(c_load + c_mult + c_acc + c_clr), 32'd0);

      // Abort sampled in cycle 20, then a fresh run.
      clr_counts();
      num_tiles = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 2; i <= 20; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy",    32'(busy),    32'd0);
      chk("ab_aborted", 32'(aborted), 32'd1);
      chk("ab_mult",    32'(mult_en), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("ab_done_cnt", 32'(c_done), 32'd0);
      chk("ab_ab_cnt",   32'(c_ab),   32'd1);
      clr_counts();
      num_tiles = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 2; i <= 15; i++) tick();
      chk("rerun_clr_cnt",  32'(c_clr),  32'd1);
      chk("rerun_done_cnt", 32'(c_done), 32'd1);

      // Start held high: runs repeat every 15 cycles.
      clr_counts();
      num_tiles = 8'd1; start = 1'b1;
      for (int i = 1; i <= 45; i++) tick();
      start = 1'b0;
      chk("held_done_cnt", 32'(c_done), 32'd3);
      chk("held_clr_cnt",  32'(c_clr),  32'd3);
      tick();

      // Start and abort together in idle: nothing starts.
      clr_counts();
      start = 1'b1; abort = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy_cnt", 32'(c_busy), 32'd0);

      // Asynchronous reset in LOAD.
      clr_counts();
      num_tiles = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("rst_pre_load", 32'(load_en), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #10;
      rst_n = 1'b1;
      #1;
      check_all();
      clr_counts();
      for (int i = 0; i < 10; i++) tick();
      chk("rst_done_cnt", 32'(c_done), 32'd0);
      chk("rst_ab_cnt",   32'(c_ab),   32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 700; i++) begin
         start     = ($urandom_range(0, 2) == 0);
         abort     = ($urandom_range(0, 49) == 0);
         num_tiles = TW'($urandom_range(0, 3));
         tick();
      end
      start = 1'b0; abort = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
